// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: redirect inputs, I-cache request/response and the IF/ID packet.
// master = the fetch unit itself (drives cache address and packet); slave = its environment.
package ifetch_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic            valid;
    } if_id_packet_t;
endpackage

interface ifetch_unit_if;
    import ifetch_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] certain_branch_pc;
    logic            certain_branch_req;
    logic [XLEN-1:0] branch_pred_pc;
    logic            branch_pred_req;
    logic [63:0]     Icache2proc_data;
    logic            Icache2proc_data_valid;
    if_id_packet_t   if_packet;
    logic [XLEN-1:0] proc2Icache_addr;

    modport master (
        input  if_valid, certain_branch_pc, certain_branch_req,
               branch_pred_pc, branch_pred_req,
               Icache2proc_data, Icache2proc_data_valid,
        output if_packet, proc2Icache_addr
    );

    modport slave (
        output if_valid, certain_branch_pc, certain_branch_req,
               branch_pred_pc, branch_pred_req,
               Icache2proc_data, Icache2proc_data_valid,
        input  if_packet, proc2Icache_addr
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, redirect mux (EX branch > prediction > sequential), word slice.
// Latency: address and packet are combinational from fetch_pc; one instruction per cycle on hit.
// Backpressure: if_valid=0 or a cache miss holds the PC (redirects captured). IFETCH_MISALIGN_CHECK_EN adds fetch_misaligned.
module ifetch_unit
    import ifetch_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    ifetch_unit_if.master bus
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic          fetch_misaligned
`endif
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] seq_pc;
    logic [31:0]     sel_word;
    logic            pkt_valid;

    always_comb begin
        fetch_pc = pc_reg;
        if (bus.certain_branch_req) begin
            fetch_pc = bus.certain_branch_pc;
        end else if (bus.branch_pred_req) begin
            fetch_pc = bus.branch_pred_pc;
        end
    end

    assign seq_pc   = fetch_pc + XLEN'(4);
    assign sel_word = fetch_pc[2] ? bus.Icache2proc_data[63:32] : bus.Icache2proc_data[31:0];

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign fetch_misaligned = (fetch_pc[1:0] != 2'b00);
    // A misaligned fetch never issues; the PC parks until a redirect replaces it.
    assign pkt_valid = bus.if_valid & bus.Icache2proc_data_valid & ~reset & ~fetch_misaligned;
`else
    assign pkt_valid = bus.if_valid & bus.Icache2proc_data_valid & ~reset;
`endif

    assign bus.proc2Icache_addr = fetch_pc;

    always_comb begin
        bus.if_packet       = '0;
        bus.if_packet.inst  = pkt_valid ? sel_word : NOP;
        bus.if_packet.pc    = fetch_pc;
        bus.if_packet.npc   = seq_pc;
        bus.if_packet.valid = pkt_valid;
    end

    // Holding fetch_pc (not pc_reg) on a stall latches any redirect seen that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= '0;
        end else if (pkt_valid) begin
            pc_reg <= seq_pc;
        end else begin
            pc_reg <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed + random bench for ifetch_unit against a cycle-level reference model of the fetch PC.
module tb_ifetch_unit;
    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] model_pc;

    always #5 clock = ~clock;

    ifetch_unit_if bus();

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fetch_misaligned;
    ifetch_unit dut (.clock(clock), .reset(reset), .bus(bus), .fetch_misaligned(fetch_misaligned));
`else
    ifetch_unit dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_fetch_pc();
        if (bus.certain_branch_req) return bus.certain_branch_pc;
        if (bus.branch_pred_req)    return bus.branch_pred_pc;
        return model_pc;
    endfunction

    function automatic logic mdl_valid();
        logic v;
        v = bus.if_valid && bus.Icache2proc_data_valid && !reset;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (mdl_fetch_pc() % 4 != 0) v = 1'b0;
`endif
        return v;
    endfunction

    // Check all outputs against the model at the falling edge.
    task automatic sample(input string tag);
        logic [31:0] f;
        logic [31:0] exp_inst;
        logic        v;
        @(negedge clock);
        f = mdl_fetch_pc();
        v = mdl_valid();
        if (!v)             exp_inst = TB_NOP;
        else if (f % 8 >= 4) exp_inst = bus.Icache2proc_data[63:32];
        else                exp_inst = bus.Icache2proc_data[31:0];
        chk({tag, ".addr"},  bus.proc2Icache_addr, f);
        chk({tag, ".valid"}, {31'b0, bus.if_packet.valid}, {31'b0, v});
        chk({tag, ".inst"},  bus.if_packet.inst, exp_inst);
        chk({tag, ".pc"},    bus.if_packet.pc, f);
        chk({tag, ".npc"},   bus.if_packet.npc, f + 32'd4);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk({tag, ".mis"},   {31'b0, fetch_misaligned}, {31'b0, (f % 4 != 0)});
`endif
    endtask

    task automatic advance();
        logic [31:0] f;
        logic        v;
        f = mdl_fetch_pc();
        v = mdl_valid();
        @(posedge clock);
        if (reset)  model_pc = 32'h0;
        else if (v) model_pc = f + 32'd4;
        else        model_pc = f;
        #1;
    endtask

    task automatic cycle(input string tag);
        sample(tag);
        advance();
    endtask

    initial begin
        reset                      = 1'b1;
        bus.if_valid               = 1'b1;
        bus.certain_branch_req     = 1'b0;
        bus.certain_branch_pc      = '0;
        bus.branch_pred_req        = 1'b0;
        bus.branch_pred_pc         = '0;
        bus.Icache2proc_data       = 64'hBBBB_BBBB_AAAA_AAAA;
        bus.Icache2proc_data_valid = 1'b1;
        @(posedge clock);
        #1;
        model_pc = 32'h0;

        // Reset state
        sample("rst");
        chk("rst.addr_c", bus.proc2Icache_addr, 32'h0);
        chk("rst.valid_c", {31'b0, bus.if_packet.valid}, 32'h0);
        chk("rst.inst_c", bus.if_packet.inst, TB_NOP);
        advance();

        // Sequential fetch from 0
        reset = 1'b0;
        sample("seq0");
        chk("seq0.addr_c", bus.proc2Icache_addr, 32'h0);
        chk("seq0.inst_c", bus.if_packet.inst, 32'hAAAA_AAAA);
        chk("seq0.npc_c", bus.if_packet.npc, 32'h4);
        advance();
        sample("seq1");
        chk("seq1.addr_c", bus.proc2Icache_addr, 32'h4);
        chk("seq1.inst_c", bus.if_packet.inst, 32'hBBBB_BBBB);
        advance();

        // Both requests: certain branch wins, visible before the clock edge
        bus.certain_branch_pc  = 32'h1111_1111;
        bus.certain_branch_req = 1'b1;
        bus.branch_pred_pc     = 32'h3333_3333;
        bus.branch_pred_req    = 1'b1;
        #1;
        chk("both.addr_c", bus.proc2Icache_addr, 32'h1111_1111);
        cycle("both");
        bus.certain_branch_req = 1'b0;
        bus.branch_pred_req    = 1'b0;

        // Predicted redirect, zero bubble
        bus.branch_pred_pc  = 32'h40;
        bus.branch_pred_req = 1'b1;
        sample("pred");
        chk("pred.addr_c", bus.proc2Icache_addr, 32'h40);
        chk("pred.pc_c", bus.if_packet.pc, 32'h40);
        chk("pred.npc_c", bus.if_packet.npc, 32'h44);
        advance();
        bus.branch_pred_req = 1'b0;
        sample("pred1");
        chk("pred1.addr_c", bus.proc2Icache_addr, 32'h44);
        advance();

        // Redirect pulse during a 3-cycle miss is captured
        bus.Icache2proc_data_valid = 1'b0;
        cycle("miss0");
        bus.certain_branch_pc  = 32'h200;
        bus.certain_branch_req = 1'b1;
        sample("miss1");
        chk("miss1.valid_c", {31'b0, bus.if_packet.valid}, 32'h0);
        advance();
        bus.certain_branch_req = 1'b0;
        cycle("miss2");
        bus.Icache2proc_data_valid = 1'b1;
        sample("hit");
        chk("hit.addr_c", bus.proc2Icache_addr, 32'h200);
        chk("hit.valid_c", {31'b0, bus.if_packet.valid}, 32'h1);
        advance();

        // Stall at 0x10
        bus.if_valid        = 1'b0;
        bus.branch_pred_pc  = 32'h10;
        bus.branch_pred_req = 1'b1;
        cycle("stl0");
        bus.branch_pred_req = 1'b0;
        sample("stl1");
        chk("stl1.addr_c", bus.proc2Icache_addr, 32'h10);
        chk("stl1.valid_c", {31'b0, bus.if_packet.valid}, 32'h0);
        chk("stl1.inst_c", bus.if_packet.inst, TB_NOP);
        advance();
        bus.if_valid = 1'b1;
        sample("stl2");
        chk("stl2.pc_c", bus.if_packet.pc, 32'h10);
        chk("stl2.inst_c", bus.if_packet.inst, 32'hAAAA_AAAA);
        chk("stl2.valid_c", {31'b0, bus.if_packet.valid}, 32'h1);
        advance();

        // Reset mid-stream (at 0x80, then during a miss with a pending redirect)
        bus.branch_pred_pc  = 32'h80;
        bus.branch_pred_req = 1'b1;
        sample("r80");
        chk("r80.addr_c", bus.proc2Icache_addr, 32'h80);
        advance();
        bus.branch_pred_req        = 1'b0;
        bus.Icache2proc_data_valid = 1'b0;
        bus.certain_branch_pc      = 32'h300;
        bus.certain_branch_req     = 1'b1;
        cycle("rmiss");
        bus.certain_branch_req = 1'b0;
        reset = 1'b1;
        bus.Icache2proc_data_valid = 1'b1;
        sample("rhi0");
        chk("rhi0.valid_c", {31'b0, bus.if_packet.valid}, 32'h0);
        advance();
        cycle("rhi1");
        reset = 1'b0;
        sample("rpost");
        chk("rpost.addr_c", bus.proc2Icache_addr, 32'h0);
        advance();

        // NPC wraps at the top of the address space
        bus.certain_branch_pc  = 32'hFFFF_FFFC;
        bus.certain_branch_req = 1'b1;
        sample("wrap");
        chk("wrap.npc_c", bus.if_packet.npc, 32'h0);
        advance();
        bus.certain_branch_req = 1'b0;
        sample("wrap1");
        chk("wrap1.addr_c", bus.proc2Icache_addr, 32'h0);
        advance();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset                      = ($urandom_range(0, 99) < 3);
            bus.if_valid               = ($urandom_range(0, 99) < 85);
            bus.Icache2proc_data_valid = ($urandom_range(0, 99) < 80);
            bus.Icache2proc_data       = {$urandom, $urandom};
            bus.certain_branch_req     = ($urandom_range(0, 99) < 15);
            bus.branch_pred_req        = ($urandom_range(0, 99) < 20);
            bus.certain_branch_pc      = $urandom & 32'hFFFF_FFFC;
            bus.branch_pred_pc         = $urandom;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
